score_digits_drawer: RTL

Drawing-request producer for the numbers layer of the VGA object mux. It takes a binary score and, once per frame, converts it to BCD with a sequential double-dabble engine. It then renders each digit as an 8x16 font glyph scaled 2x, placed at a fixed screen box. Outputs are one drawing request and one RGB byte per digit, which feed the mux's per-digit numbers DR/RGB inputs directly.

---
 rtl/score_digits_drawer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/score_digits_drawer.sv
`timescale 1ns/1ps
// score_digits_drawer
// Numbers-layer drawing-request producer for the VGA object mux.
// A binary score is converted to BCD once per frame by a sequential
// double-dabble engine. Each decimal digit is then drawn as an 8x16 font
// glyph scaled 2x inside a fixed 16x32 pixel box.
//
// Ports
//   clk           pixel clock
//   resetN        synchronous reset, asserted high
//   startOfFrame  one-cycle pulse, launches a conversion when idle
//   score         binary score, captured when a conversion is accepted
//   pixelX/Y      current pixel coordinates
//   numbersDR     per-digit drawing request (registered, latency 1)
//   numbersRGB    per-digit colour (COLOR where drawn, else 0)
//   busy          conversion in progress
//
// state  | meaning
// IDLE   | display stable, waiting for startOfFrame
// LOAD   | clear BCD register, load iteration counter
// SHIFT  | one double-dabble iteration per cycle
// COMMIT | copy BCD result into the display digits
module score_digits_drawer #(
    parameter int         DIGITS    = 3,
    parameter int         SCORE_W   = 10,
    parameter int         TOPLEFT_X = 16,
    parameter int         TOPLEFT_Y = 8,
    parameter logic [7:0] COLOR     = 8'hFF
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     startOfFrame,
    input  logic [SCORE_W-1:0]       score,
    input  logic [10:0]              pixelX,
    input  logic [10:0]              pixelY,
    output logic [DIGITS-1:0]        numbersDR,
    output logic [DIGITS-1:0][7:0]   numbersRGB,
    output logic                     busy
);

    function automatic int pow10(input int n);
        int p;
        p = 1;
        for (int k = 0; k < n; k++) p = p * 10;
        return p;
    endfunction

    localparam int                 MAX_VAL   = pow10(DIGITS) - 1;
    localparam logic [SCORE_W-1:0] MAX_SCORE = SCORE_W'(MAX_VAL);
    localparam int                 CNT_W     = $clog2(SCORE_W + 1);
    localparam logic [10:0]        BOX_TOP   = 11'(TOPLEFT_Y);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;

    state_t                  state, state_next;
    logic [SCORE_W-1:0]      bin;
    logic [DIGITS-1:0][3:0]  bcd, bcd_adj, disp;
    logic [CNT_W-1:0]        cnt;
    logic [DIGITS-1:0]       blank, dr_next;

    // Standard 8x16 digit glyphs, row 0 in the top byte, bit 7 leftmost.
    function automatic logic [7:0] font_row(input logic [3:0] d, input logic [3:0] r);
        logic [127:0] g;
        case (d)
            4'd0:    g = 128'h00007CC6C6CEDEF6E6C6C67C00000000;
            4'd1:    g = 128'h00001838781818181818187E00000000;
            4'd2:    g = 128'h00007CC6060C183060C0C6FE00000000;
            4'd3:    g = 128'h00007CC606063C060606C67C00000000;
            4'd4:    g = 128'h00000C1C3C6CCCFE0C0C0C1E00000000;
            4'd5:    g = 128'h0000FEC0C0C0FC060606C67C00000000;
            4'd6:    g = 128'h00003860C0C0FCC6C6C6C67C00000000;
            4'd7:    g = 128'h0000FEC606060C183030303000000000;
            4'd8:    g = 128'h00007CC6C6C67CC6C6C6C67C00000000;
            4'd9:    g = 128'h00007CC6C6C67E0606060C7800000000;
            default: g = '0;
        endcase
        // top bit of row r sits at 8*(15-r)+7, i.e. {~r, 3'b111}
        return g[{~r, 3'b111} -: 8];
    endfunction

    always_ff @(posedge clk) begin
        if (resetN) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        case (state)
            IDLE:    if (startOfFrame) state_next = LOAD;
            LOAD:    state_next = SHIFT;
            SHIFT:   if (cnt == CNT_W'(1)) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++)
            if (bcd[i] >= 4'd5) bcd_adj[i] = bcd[i] + 4'd3;
    end

    always_ff @(posedge clk) begin
        if (resetN) begin
            bin  <= '0;
            bcd  <= '0;
            cnt  <= '0;
            disp <= '0;
        end else begin
            // score is only looked at on the accepting edge, so later changes
            // cannot disturb a conversion in flight
            if (state == IDLE && startOfFrame)
                bin <= (score > MAX_SCORE) ? MAX_SCORE : score;
            case (state)
                LOAD: begin
                    bcd <= '0;
                    cnt <= CNT_W'(SCORE_W);
                end
                SHIFT: begin
                    {bcd, bin} <= {bcd_adj, bin} << 1;
                    cnt        <= cnt - CNT_W'(1);
                end
                COMMIT:  disp <= bcd;
                default: ;
            endcase
        end
    end

    // A digit is blank when it and every more significant digit are zero;
    // digit 0 always shows.
    always_comb begin
        logic lz;
        lz    = 1'b1;
        blank = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lz       = lz & (disp[i] == 4'd0);
            blank[i] = lz && (i != 0);
        end
    end

    // Subtractions are only consumed inside the box compare, so out-of-box
    // wraparound never reaches the font lookup.
    always_comb begin
        logic [10:0] left;
        logic [3:0]  row;
        logic [2:0]  col;
        logic [7:0]  glyph;
        dr_next = '0;
        left    = '0;
        row     = '0;
        col     = '0;
        glyph   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            left = 11'(TOPLEFT_X + (DIGITS - 1 - i) * 16);
            if (pixelX >= left && pixelX <= left + 11'd15 &&
                pixelY >= BOX_TOP && pixelY <= BOX_TOP + 11'd31 && !blank[i]) begin
                row        = 4'((pixelY - BOX_TOP) >> 1);
                col        = 3'((pixelX - left) >> 1);
                glyph      = font_row(disp[i], row);
                dr_next[i] = glyph[~col];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (resetN) begin
            numbersDR  <= '0;
            numbersRGB <= '0;
        end else begin
            numbersDR <= dr_next;
            for (int i = 0; i < DIGITS; i++)
                numbersRGB[i] <= dr_next[i] ? COLOR : 8'h00;
        end
    end

endmodule
